// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that fills instruction RAM and holds the CPU until done.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHKSUM_EN.
module imem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic                  start_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  err_o
);
  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CHK, DONE} state_t;
`ifdef IMEM_LOADER_CHKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = DONE;
`endif
  localparam logic [31:0] MAXW = 32'(MAX_WORDS);
  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ovf_q, ovf_d;
  logic                  rdy_q, rdy_d;
  logic                  cerr_q;
  logic                  acc, last, in_range;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic                  cerr_d;
`else
  assign cerr_q = 1'b0;
`endif
  assign byte_ready_o = rdy_q && state_q != DONE;
  assign acc          = byte_valid_i && byte_ready_o;
  assign last         = idx_q == count_q - 16'd1;
  assign in_range     = {16'd0, idx_q} < MAXW;
  assign mem_we_o     = we_q;
  assign mem_waddr_o  = waddr_q;
  assign mem_wdata_o  = wdata_q;
  assign done_o       = state_q == DONE;
  assign cpu_hold_o   = !done_o;
  assign err_o        = done_o && (ovf_q || cerr_q);
  // next-state: header capture, word assembly with one-cycle write strobe, checksum, restart
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    rdy_d   = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
    sum_d   = (acc && state_q != CHK) ? sum_q + byte_i : sum_q;
    cerr_d  = cerr_q;
`endif
    case (state_q)
      HDR_LO: if (acc) begin
        count_d[7:0] = byte_i;
        state_d      = HDR_HI;
      end
      HDR_HI: if (acc) begin
        count_d[15:8] = byte_i;
        state_d       = ({byte_i, count_q[7:0]} == 16'd0) ? TAIL : DATA;
      end
      DATA: if (acc) begin
        bcnt_d = bcnt_q + 2'd1;
        word_d = {byte_i, word_q[23:8]};
        if (bcnt_q == 2'd3) begin
          we_d    = in_range;
          waddr_d = in_range ? BASE_ADDR + ADDR_WIDTH'({idx_q, 2'b00}) : waddr_q;
          wdata_d = in_range ? {byte_i, word_q} : wdata_q;
          ovf_d   = ovf_q || !in_range;
          idx_d   = idx_q + 16'd1;
          state_d = last ? TAIL : DATA;
        end
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      CHK: if (acc) begin
        cerr_d  = (sum_q + byte_i) != 8'h00;
        state_d = DONE;
      end
`endif
      DONE: if (start_i) begin
        state_d = HDR_LO;
        count_d = '0;
        idx_d   = '0;
        bcnt_d  = '0;
        ovf_d   = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
        sum_d   = '0;
        cerr_d  = 1'b0;
`endif
      end
      default: state_d = HDR_LO;
    endcase
  end
  // state and datapath registers, cleared asynchronously so a reset mid-load drops everything
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= HDR_LO;
      count_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end
`ifdef IMEM_LOADER_CHKSUM_EN
  // running checksum and its verdict
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sum_q  <= '0;
      cerr_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cerr_q <= cerr_d;
    end
  end
`endif
endmodule
